// File: rtl/wall_follower_nav.sv
// Maze wall follower: debounces four absolute wall sensors, picks a move with the
// left- or right-hand rule, and hands it to a motion unit over a valid/ready link.
module wall_follower_nav #(
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       hand_sel,
  input  logic [3:0] sensor,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_cmd,
  output logic [1:0] heading,
  output logic [7:0] turn_count,
  output logic       fault
);

  localparam logic [7:0]  DEB_LAST  = 8'(DEB_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  localparam logic [1:0] CMD_FWD    = 2'b00;
  localparam logic [1:0] CMD_LEFT   = 2'b01;
  localparam logic [1:0] CMD_RIGHT  = 2'b10;
  localparam logic [1:0] CMD_AROUND = 2'b11;

  typedef enum logic [2:0] {IDLE, SENSE, ISSUE, SETTLE, FAULT} state_t;

  state_t      state_reg, state_next;
  logic [15:0] wait_reg, wait_next;
  logic [7:0]  settle_reg, settle_next;
  logic        move_valid_reg, move_valid_next;
  logic [1:0]  move_cmd_reg, move_cmd_next;
  logic [1:0]  heading_reg, heading_next;
  logic [7:0]  turn_count_reg, turn_count_next;
  logic        fault_reg, fault_next;
  logic        accept;
  logic [3:0]  filt;

  // Per-bit debounce: the counter tracks how long the raw bit has disagreed with the filtered bit.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
      logic       filt_reg;
      logic [7:0] deb_cnt_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          filt_reg    <= 1'b0;
          deb_cnt_reg <= '0;
        end else if (sensor[gi] == filt_reg) begin
          deb_cnt_reg <= '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          filt_reg    <= sensor[gi];
          deb_cnt_reg <= '0;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + 8'd1;
        end
      end

      assign filt[gi] = filt_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      wait_reg       <= '0;
      settle_reg     <= '0;
      move_valid_reg <= 1'b0;
      move_cmd_reg   <= CMD_FWD;
      heading_reg    <= 2'b00;
      turn_count_reg <= '0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wait_reg       <= wait_next;
      settle_reg     <= settle_next;
      move_valid_reg <= move_valid_next;
      move_cmd_reg   <= move_cmd_next;
      heading_reg    <= heading_next;
      turn_count_reg <= turn_count_next;
      fault_reg      <= fault_next;
    end
  end

  // A ready seen on the final allowed ISSUE cycle still wins over the timeout.
  always_comb begin
    state_next  = state_reg;
    wait_next   = wait_reg;
    settle_next = settle_reg;
    accept      = 1'b0;
    case (state_reg)
      IDLE: if (en) state_next = SENSE;
      SENSE: begin
        state_next = ISSUE;
        wait_next  = '0;
      end
      ISSUE: begin
        if (move_ready) begin
          accept      = 1'b1;
          state_next  = SETTLE;
          settle_next = '0;
        end else if (wait_reg == WAIT_LAST) begin
          state_next = FAULT;
          wait_next  = '0;
        end else begin
          wait_next = wait_reg + 16'd1;
        end
      end
      SETTLE: begin
        if (settle_reg == DEB_LAST) begin
          settle_next = '0;
          state_next  = en ? SENSE : IDLE;
        end else begin
          settle_next = settle_reg + 8'd1;
        end
      end
      FAULT: if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [1:0] pref_dir, opp_dir, decision, head_delta;

  always_comb begin
    pref_dir = hand_sel ? heading_reg + 2'd1 : heading_reg - 2'd1;
    opp_dir  = hand_sel ? heading_reg - 2'd1 : heading_reg + 2'd1;
    if (!filt[pref_dir])         decision = hand_sel ? CMD_RIGHT : CMD_LEFT;
    else if (!filt[heading_reg]) decision = CMD_FWD;
    else if (!filt[opp_dir])     decision = hand_sel ? CMD_LEFT : CMD_RIGHT;
    else                         decision = CMD_AROUND;

    case (move_cmd_reg)
      CMD_LEFT:   head_delta = 2'd3;
      CMD_RIGHT:  head_delta = 2'd1;
      CMD_AROUND: head_delta = 2'd2;
      default:    head_delta = 2'd0;
    endcase
  end

  always_comb begin
    move_valid_next = (state_next == ISSUE);
    fault_next      = (state_next == FAULT);
    move_cmd_next   = (state_reg == SENSE) ? decision : move_cmd_reg;
    heading_next    = accept ? heading_reg + head_delta : heading_reg;
    turn_count_next = turn_count_reg;
    if (accept && move_cmd_reg != CMD_FWD && turn_count_reg != 8'hFF)
      turn_count_next = turn_count_reg + 8'd1;
  end

  assign move_valid = move_valid_reg;
  assign move_cmd   = move_cmd_reg;
  assign heading    = heading_reg;
  assign turn_count = turn_count_reg;
  assign fault      = fault_reg;

endmodule

// File: tb/tb_wall_follower_nav.sv
// Self-checking bench for wall_follower_nav: a behavioural reference is compared
// against the DUT every cycle, plus directed literal checks of key scenarios.
module tb_wall_follower_nav;

  localparam int DEB = 4;
  localparam int TMO = 37;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       hand_sel = 1'b0;
  logic [3:0] sensor = 4'b0000;
  logic       move_ready = 1'b1;
  logic       move_valid;
  logic [1:0] move_cmd;
  logic [1:0] heading;
  logic [7:0] turn_count;
  logic       fault;

  wall_follower_nav #(.DEB_CYCLES(DEB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .hand_sel(hand_sel), .sensor(sensor),
    .move_ready(move_ready), .move_valid(move_valid), .move_cmd(move_cmd),
    .heading(heading), .turn_count(turn_count), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  typedef enum int {M_IDLE, M_LOOK, M_OFFER, M_WAIT, M_STUCK} mode_t;
  mode_t      m_mode;
  logic [3:0] m_filt, m_last;
  int         m_run[4];
  int         m_waited, m_left;
  int         m_head, m_turns;
  logic [1:0] m_cmd;
  bit         m_valid, m_fault;

  function automatic logic [1:0] decide(input bit hand, input logic [3:0] f, input int h);
    int side, other;
    side  = hand ? (h + 1) % 4 : (h + 3) % 4;
    other = hand ? (h + 3) % 4 : (h + 1) % 4;
    if (f[side] == 1'b0)  return hand ? 2'b10 : 2'b01;
    if (f[h] == 1'b0)     return 2'b00;
    if (f[other] == 1'b0) return hand ? 2'b01 : 2'b10;
    return 2'b11;
  endfunction

  function automatic int turn_amount(input logic [1:0] c);
    case (c)
      2'b01:   return 3;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 0;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_mode = M_IDLE; m_filt = 4'b0; m_last = 4'b0;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        m_waited = 0; m_left = 0; m_head = 0; m_turns = 0;
        m_cmd = 2'b00; m_valid = 1'b0; m_fault = 1'b0;
      end else begin
        case (m_mode)
          M_IDLE: if (en) m_mode = M_LOOK;
          M_LOOK: begin
            m_cmd = decide(hand_sel, m_filt, m_head);
            m_mode = M_OFFER; m_waited = 0; m_valid = 1'b1;
          end
          M_OFFER: begin
            if (move_ready) begin
              m_head = (m_head + turn_amount(m_cmd)) % 4;
              if (m_cmd != 2'b00 && m_turns < 255) m_turns++;
              m_mode = M_WAIT; m_left = DEB; m_valid = 1'b0;
            end else begin
              m_waited++;
              if (m_waited == TMO) begin
                m_mode = M_STUCK; m_valid = 1'b0; m_fault = 1'b1;
              end
            end
          end
          M_WAIT: begin
            m_left--;
            if (m_left == 0) m_mode = en ? M_LOOK : M_IDLE;
          end
          M_STUCK: if (!en) begin
            m_mode = M_IDLE; m_fault = 1'b0;
          end
          default: m_mode = M_IDLE;
        endcase
        // A filtered bit follows the raw bit once it has held one value for DEB samples.
        for (int b = 0; b < 4; b++) begin
          if (sensor[b] == m_last[b]) m_run[b]++;
          else m_run[b] = 1;
          m_last[b] = sensor[b];
          if (m_run[b] >= DEB) m_filt[b] = sensor[b];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("move_valid", int'(move_valid), int'(m_valid));
      check("move_cmd",   int'(move_cmd),   int'(m_cmd));
      check("heading",    int'(heading),    m_head);
      check("turn_count", int'(turn_count), m_turns);
      check("fault",      int'(fault),      int'(m_fault));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    cyc(3);
    cmp_on = 1'b1;
    check("rst_valid", int'(move_valid), 0);
    check("rst_cmd", int'(move_cmd), 0);
    check("rst_heading", int'(heading), 0);
    check("rst_turns", int'(turn_count), 0);
    check("rst_fault", int'(fault), 0);

    // Left-hand, open maze: turn left, heading UP -> LEFT.
    rst = 1'b1; cyc(DEB + 1);
    en = 1'b1; cyc(1);
    check("lat_sense_valid", int'(move_valid), 0);
    cyc(1);
    check("lh_valid", int'(move_valid), 1);
    check("lh_cmd", int'(move_cmd), 1);
    en = 1'b0; cyc(1);
    check("lh_heading", int'(heading), 3);
    check("lh_turns", int'(turn_count), 1);
    check("lh_valid_drop", int'(move_valid), 0);
    cyc(DEB + 2);

    // Right-hand, right wall present: go forward.
    rst = 1'b0; sensor = 4'b0010; hand_sel = 1'b1; cyc(1);
    rst = 1'b1; cyc(DEB + 1);
    en = 1'b1; cyc(2); en = 1'b0;
    check("rh_cmd", int'(move_cmd), 0);
    cyc(1);
    check("rh_heading", int'(heading), 0);
    check("rh_turns", int'(turn_count), 0);
    cyc(DEB + 2);

    // Dead end from LEFT, then left turn from RIGHT wrapping to UP.
    rst = 1'b0; sensor = 4'b0000; hand_sel = 1'b0; cyc(1);
    rst = 1'b1; cyc(DEB + 1);
    en = 1'b1; cyc(2); en = 1'b0;
    check("de_first_cmd", int'(move_cmd), 1);
    cyc(1);
    check("de_first_heading", int'(heading), 3);
    sensor = 4'b1111; cyc(DEB + 2);
    en = 1'b1; cyc(2); en = 1'b0;
    check("de_cmd", int'(move_cmd), 3);
    cyc(1);
    check("de_heading", int'(heading), 1);
    sensor = 4'b1110; cyc(DEB + 2);
    en = 1'b1; cyc(2); en = 1'b0;
    check("wrap_cmd", int'(move_cmd), 1);
    cyc(1);
    check("wrap_heading", int'(heading), 0);
    check("wrap_turns", int'(turn_count), 3);
    cyc(DEB + 2);

    // Glitch on bit0 for DEB-1 samples must not change the decision.
    sensor = 4'b1111; cyc(DEB - 1);
    sensor = 4'b1110;
    en = 1'b1; cyc(2); en = 1'b0;
    check("glitch_cmd", int'(move_cmd), 0);
    cyc(1);
    check("glitch_heading", int'(heading), 0);
    cyc(DEB + 2);

    // Handshake timeout.
    move_ready = 1'b0; en = 1'b1; cyc(2);
    check("to_valid_start", int'(move_valid), 1);
    cyc(TMO - 1);
    check("to_valid_last", int'(move_valid), 1);
    check("to_fault_early", int'(fault), 0);
    cyc(1);
    check("to_fault", int'(fault), 1);
    check("to_valid_off", int'(move_valid), 0);
    cyc(3);
    check("to_fault_hold", int'(fault), 1);
    en = 1'b0; cyc(1);
    check("to_fault_clear", int'(fault), 0);
    move_ready = 1'b1; cyc(2);

    // Reset while a command is pending.
    move_ready = 1'b0; en = 1'b1; cyc(2);
    check("ri_valid", int'(move_valid), 1);
    rst = 1'b0; cyc(1);
    check("ri_valid_off", int'(move_valid), 0);
    check("ri_cmd", int'(move_cmd), 0);
    check("ri_turns", int'(turn_count), 0);
    check("ri_fault", int'(fault), 0);
    rst = 1'b1; en = 1'b0; move_ready = 1'b1; cyc(DEB + 1);

    // Turn counter saturation: more than 256 accepted left turns.
    sensor = 4'b0000; hand_sel = 1'b0; en = 1'b1;
    cyc(260 * (DEB + 2));
    check("sat_turns", int'(turn_count), 255);
    en = 1'b0; cyc(DEB + 3);

    // Randomized traffic against the reference.
    for (int c = 0; c < 6000; c++) begin
      int r;
      rst = ($urandom_range(0, 399) != 0);
      en = ($urandom_range(0, 9) < 8);
      if ((c / 300) % 4 == 3) move_ready = ($urandom_range(0, 39) == 0);
      else move_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 49) == 0) hand_sel = ~hand_sel;
      r = $urandom_range(0, 29);
      if (r < 3) sensor = 4'($urandom_range(0, 15));
      else if (r < 5) sensor[$urandom_range(0, 3)] = ~sensor[$urandom_range(0, 3)];
      cyc(1);
    end

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wall_follower_nav.md
WALL_FOLLOWER_NAV -- requirements
Module: wall_follower_nav

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 4, giving the consecutive raw samples needed to change a filtered sensor bit (legal range 1..255).
REQ-002 The block SHALL have parameter TIMEOUT, default 1023, giving the maximum cycles move_valid may wait for move_ready before a fault (legal range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: navigation enable.
REQ-006 The block SHALL have port hand_sel, input, 1 bit: 0 = left-hand rule, 1 = right-hand rule.
REQ-007 The block SHALL have port sensor, input, 4 bits: absolute wall detect, 1 = wall; bit0 UP, bit1 RIGHT, bit2 DOWN, bit3 LEFT.
REQ-008 The block SHALL have port move_ready, input, 1 bit: motion unit accepts the command.
REQ-009 The block SHALL have port move_valid, output, 1 bit: command valid.
REQ-010 The block SHALL have port move_cmd, output, 2 bits: 00 forward, 01 turn left, 10 turn right, 11 turn around.
REQ-011 The block SHALL have port heading, output, 2 bits: 00 UP, 01 RIGHT, 10 DOWN, 11 LEFT.
REQ-012 The block SHALL have port turn_count, output, 8 bits: count of accepted non-forward commands.
REQ-013 The block SHALL have port fault, output, 1 bit: handshake timeout occurred.

Function
REQ-014 Each sensor bit SHALL be debounced independently: the filtered bit takes a new raw value on the edge completing DEB_CYCLES consecutive samples of that value; any differing sample restarts that bit's count.
REQ-015 The FSM SHALL have states IDLE, SENSE, ISSUE, SETTLE and FAULT.
REQ-016 IDLE SHALL go to SENSE on the edge where en=1, and stay in IDLE otherwise.
REQ-017 SENSE SHALL last one cycle: it samples hand_sel and the filtered sensors, latches move_cmd, and goes to ISSUE; move_valid therefore rises 2 cycles after en is first sampled high.
REQ-018 The decision priority SHALL be: preferred side open -> turn toward it; else front open -> forward; else opposite side open -> turn toward it; else turn around. The preferred side is heading-1 for left-hand and heading+1 for right-hand; open means the filtered bit is 0.
REQ-019 In ISSUE, move_valid SHALL be 1 and move_cmd SHALL stay constant until move_valid and move_ready are both 1 on a clock edge (accept).
REQ-020 On accept, heading SHALL update modulo 4: left -1, right +1, around +2, forward unchanged (LEFT+1 wraps to UP; UP-1 wraps to LEFT). The state SHALL then go to SETTLE with move_valid=0 on the next cycle.
REQ-021 On accept of a non-forward command, turn_count SHALL increment, saturating at 255.
REQ-022 A wait counter SHALL count ISSUE cycles without accept. When it reaches TIMEOUT, the block SHALL go to FAULT with move_valid=0; move_ready in that same cycle SHALL still count as accept.
REQ-023 In FAULT, fault SHALL be 1 and no command is issued; the block SHALL go to IDLE (fault cleared) on the edge where en=0.
REQ-024 SETTLE SHALL last DEB_CYCLES cycles, then go to SENSE if en=1, else to IDLE.
REQ-025 en=0 SHALL be ignored in ISSUE; a pending command always completes or times out.
REQ-026 move_valid SHALL be registered and be 1 only in ISSUE.

Reset
REQ-027 While rst=0 at a clock edge, the block SHALL set: state IDLE, heading UP, move_valid 0, move_cmd 00, turn_count 0, fault 0, filtered sensors 0, and all debounce, wait and settle counters 0.
REQ-028 Reset in any state, including ISSUE with move_valid=1, SHALL take effect on that edge; no accept is recorded.

Verification
REQ-029 Left-hand, heading UP, sensor=0000 held DEB_CYCLES cycles, en=1, ready=1 -> move_cmd=01, heading UP->LEFT(11), turn_count=1.
REQ-030 Right-hand, heading UP, sensor=0010 (right wall), ready=1 -> move_cmd=00, heading stays 00, turn_count unchanged.
REQ-031 Dead end: sensor=1111 from heading LEFT -> move_cmd=11, heading=01; heading RIGHT with left turn -> 00 (wrap check).
REQ-032 move_ready=0 for TIMEOUT cycles -> fault=1, move_valid=0; then en=0 -> IDLE, fault=0.
REQ-033 Raw sensor bit glitch of DEB_CYCLES-1 cycles -> filtered bit unchanged; command unaffected.
REQ-034 rst=0 while in ISSUE -> next cycle move_valid=0 and all outputs at reset values; 256 accepted turns -> turn_count stays 255.
